// File: rtl/rtype_issue_decoder.sv
// R-type issue decoder: accepts 32-bit MIPS words, filters illegal encodings, issues fields to the ALU.
// Latency: one cycle from input accept to out_valid; illegal pulse also one cycle after accept.
// Backpressure: single-entry output register; in_ready = !out_valid || out_ready in RUN, 0 in DRAIN/HALTED.
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr  instruction word handshake
//   out_valid/out_ready         decoded-field handshake toward the ALU
//   rs, rt, rd, shamt, funct    decoded fields, held stable while out_valid && !out_ready
//   resume / halted             release pulse and HALTED indication for BREAK handling
//   illegal                     one-cycle pulse per consumed illegal word
//   issued_count/illegal_count  saturating event counters
// Optional build macro: SHAMT_CHECK_EN -- also rejects add/sub/and/or with shamt != 0
// and sll/srl with rs != 0.
module rtype_issue_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   input  logic             resume,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] issued_count,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_BREAK = 6'b001101;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
   logic [5:0]       funct_q, funct_d;
   logic             illegal_q, illegal_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   logic [5:0] opcode_in, funct_in;
   logic [4:0] rs_in, rt_in, rd_in, shamt_in;
   logic       is_alu, field_ok, is_legal, is_break;
   logic       accept, out_fire;

   assign opcode_in = in_instr[31:26];
   assign rs_in     = in_instr[25:21];
   assign rt_in     = in_instr[20:16];
   assign rd_in     = in_instr[15:11];
   assign shamt_in  = in_instr[10:6];
   assign funct_in  = in_instr[5:0];

   // Instruction classification
   always_comb begin
      is_alu   = 1'b0;
      field_ok = 1'b1;
      if (opcode_in == 6'd0) begin
         case (funct_in)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL: is_alu = 1'b1;
            default:                                        is_alu = 1'b0;
         endcase
      end
`ifdef SHAMT_CHECK_EN
      // Shifts take their amount from shamt and ignore rs; arithmetic ops the reverse.
      if (funct_in == FN_SLL || funct_in == FN_SRL) begin
         field_ok = (rs_in == 5'd0);
      end else begin
         field_ok = (shamt_in == 5'd0);
      end
`endif
      is_legal = is_alu && field_ok;
      is_break = (opcode_in == 6'd0) && (funct_in == FN_BREAK);
   end

   // Ready is forced low during reset so no word is seen as accepted while clearing.
   assign in_ready = !rst && (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      out_valid_d   = out_valid_q;
      rs_d          = rs_q;
      rt_d          = rt_q;
      rd_d          = rd_q;
      shamt_d       = shamt_q;
      funct_d       = funct_q;
      illegal_d     = 1'b0;
      issued_cnt_d  = issued_cnt_q;
      illegal_cnt_d = illegal_cnt_q;
      state_d       = state_q;

      // Output register: a legal accept reloads, otherwise a transfer empties it.
      if (accept && is_legal) begin
         out_valid_d = 1'b1;
         rs_d        = rs_in;
         rt_d        = rt_in;
         rd_d        = rd_in;
         shamt_d     = shamt_in;
         funct_d     = funct_in;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end

      if (accept && !is_legal && !is_break) begin
         illegal_d = 1'b1;
         if (illegal_cnt_q != CNT_MAX) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end

      if (out_fire && issued_cnt_q != CNT_MAX) begin
         issued_cnt_d = issued_cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_RUN:    if (accept && is_break) state_d = ST_DRAIN;
         // Leaves DRAIN in the same cycle the last pending output transfers.
         ST_DRAIN:  if (!out_valid_d) state_d = ST_HALTED;
         ST_HALTED: if (resume) state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase

      halted_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         out_valid_q   <= 1'b0;
         rs_q          <= 5'd0;
         rt_q          <= 5'd0;
         rd_q          <= 5'd0;
         shamt_q       <= 5'd0;
         funct_q       <= 6'd0;
         illegal_q     <= 1'b0;
         halted_q      <= 1'b0;
         issued_cnt_q  <= '0;
         illegal_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         rs_q          <= rs_d;
         rt_q          <= rt_d;
         rd_q          <= rd_d;
         shamt_q       <= shamt_d;
         funct_q       <= funct_d;
         illegal_q     <= illegal_d;
         halted_q      <= halted_d;
         issued_cnt_q  <= issued_cnt_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign rs            = rs_q;
   assign rt            = rt_q;
   assign rd            = rd_q;
   assign shamt         = shamt_q;
   assign funct         = funct_q;
   assign illegal       = illegal_q;
   assign halted        = halted_q;
   assign issued_count  = issued_cnt_q;
   assign illegal_count = illegal_cnt_q;

endmodule

// File: tb/tb_rtype_issue_decoder.sv
module tb_rtype_issue_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic        resume;
   logic        halted;
   logic        illegal;
   logic [7:0]  issued_count;
   logic [7:0]  illegal_count;

   int total = 0;
   int bad   = 0;

   rtype_issue_decoder #(.CNT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .rs            (rs),
      .rt            (rt),
      .rd            (rd),
      .shamt         (shamt),
      .funct         (funct),
      .resume        (resume),
      .halted        (halted),
      .illegal       (illegal),
      .issued_count  (issued_count),
      .illegal_count (illegal_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      out_ready = 1'b0;
      resume    = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_issued", 32'(issued_count), 32'h0);
      chk("rst_illcnt", 32'(illegal_count), 32'h0);
      chk("rst_funct", 32'(funct), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // add rd=2 rs=0 rt=1
      in_valid = 1'b1; in_instr = 32'h00011020; out_ready = 1'b1;
      #1;
      chk("add_in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("add_out_valid", 32'(out_valid), 32'h1);
      chk("add_rs", 32'(rs), 32'h0);
      chk("add_rt", 32'(rt), 32'h1);
      chk("add_rd", 32'(rd), 32'h2);
      chk("add_shamt", 32'(shamt), 32'h0);
      chk("add_funct", 32'(funct), 32'h20);
      tick();
      chk("add_drained", 32'(out_valid), 32'h0);
      chk("add_issued", 32'(issued_count), 32'h1);

      // srl then sub back-to-back with output stalled
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00011082;
      tick();
      in_instr = 32'h00220022;
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("srl_funct", 32'(funct), 32'h02);
      chk("srl_shamt", 32'(shamt), 32'h2);
      chk("srl_rd", 32'(rd), 32'h2);
      tick();
      tick();
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_funct", 32'(funct), 32'h02);
      chk("hold_shamt", 32'(shamt), 32'h2);
      chk("hold_rt", 32'(rt), 32'h1);
      chk("hold_issued", 32'(issued_count), 32'h1);
      out_ready = 1'b1;
      #1;
      chk("drain_in_ready", 32'(in_ready), 32'h1);
      tick();
      in_valid = 1'b0;
      chk("sub_valid", 32'(out_valid), 32'h1);
      chk("sub_funct", 32'(funct), 32'h22);
      chk("sub_rs", 32'(rs), 32'h1);
      chk("sub_rt", 32'(rt), 32'h2);
      chk("sub_rd", 32'(rd), 32'h0);
      chk("srl_issued", 32'(issued_count), 32'h2);
      tick();
      chk("sub_drained", 32'(out_valid), 32'h0);
      chk("sub_issued", 32'(issued_count), 32'h3);

      // lw is illegal
      in_valid = 1'b1; in_instr = 32'h8C010004;
      tick();
      in_valid = 1'b0;
      chk("lw_illegal", 32'(illegal), 32'h1);
      chk("lw_no_valid", 32'(out_valid), 32'h0);
      chk("lw_illcnt", 32'(illegal_count), 32'h1);
      tick();
      chk("lw_pulse_end", 32'(illegal), 32'h0);

      // illegal counter saturation
      in_valid = 1'b1;
      for (int i = 0; i < 253; i++) tick();
      chk("illcnt_fe", 32'(illegal_count), 32'hFE);
      for (int i = 0; i < 10; i++) tick();
      in_valid = 1'b0;
      tick();
      chk("illcnt_sat", 32'(illegal_count), 32'hFF);
      chk("illcnt_issued", 32'(issued_count), 32'h3);

      // all-zero word is sll r0,r0,0 and legal
      in_valid = 1'b1; in_instr = 32'h00000000;
      tick();
      in_valid = 1'b0;
      chk("zero_valid", 32'(out_valid), 32'h1);
      chk("zero_illegal", 32'(illegal), 32'h0);
      tick();
      chk("zero_issued", 32'(issued_count), 32'h4);

      // BREAK behind a pending add
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00011020;
      tick();
      in_instr = 32'h0000000D;
      #1;
      chk("brk_blocked", 32'(in_ready), 32'h0);
      tick();
      chk("brk_add_held", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      resume = 1'b1;
      chk("drain_in_ready0", 32'(in_ready), 32'h0);
      chk("drain_out_valid", 32'(out_valid), 32'h0);
      chk("drain_issued", 32'(issued_count), 32'h5);
      chk("drain_illegal", 32'(illegal), 32'h0);
      tick();
      resume = 1'b0;
      chk("halted_set", 32'(halted), 32'h1);
      in_valid = 1'b1; in_instr = 32'h00011020;
      #1;
      chk("halted_in_ready", 32'(in_ready), 32'h0);
      tick();
      in_valid = 1'b0;
      chk("halted_still", 32'(halted), 32'h1);
      chk("halted_no_issue", 32'(out_valid), 32'h0);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_in_ready", 32'(in_ready), 32'h1);

      // add with shamt=1
      in_valid = 1'b1; in_instr = 32'h00011060;
      tick();
      in_valid = 1'b0;
`ifdef SHAMT_CHECK_EN
      chk("shamt_illegal", 32'(illegal), 32'h1);
      chk("shamt_no_valid", 32'(out_valid), 32'h0);
`else
      chk("shamt_valid", 32'(out_valid), 32'h1);
      chk("shamt_val", 32'(shamt), 32'h1);
      chk("shamt_funct", 32'(funct), 32'h20);
      chk("shamt_legal", 32'(illegal), 32'h0);
`endif
      tick();

      // asynchronous reset with an output pending
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00011020;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_issued", 32'(issued_count), 32'h0);
      chk("arst_illcnt", 32'(illegal_count), 32'h0);
      chk("arst_halted", 32'(halted), 32'h0);
      chk("arst_rd", 32'(rd), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rtype_issue_decoder.md
Name: rtype_issue_decoder

Overview:
- Front end for the R-type ALU: accepts 32-bit MIPS instruction words over a valid/ready handshake, decodes them, and issues rs/rt/rd/shamt/funct to the ALU through a registered valid/ready output stage.
- Filters out unsupported encodings, counts issued and illegal instructions, and halts on a BREAK instruction until it is released.

Parameters:
- CNT_W, 8, width of the saturating issued/illegal counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder can accept an instruction this cycle.
- in_instr  in  32  instruction word: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
- out_valid  out  1  decoded fields valid to the ALU.
- out_ready  in  1  ALU accepts the fields this cycle.
- rs, rt, rd  out  5 each  register indices.
- shamt  out  5  shift amount.
- funct  out  6  ALU function code.
- resume  in  1  single-cycle pulse that releases the HALTED state.
- halted  out  1  high while in the HALTED state.
- illegal  out  1  one-cycle pulse when an illegal instruction is consumed.
- issued_count  out  CNT_W  count of instructions accepted by the ALU; saturating.
- illegal_count  out  CNT_W  count of illegal instructions; saturating.

Behaviour:
- Reset: all outputs are 0, the state is RUN, and the output register is empty.
- Legal set: opcode == 0 and funct in {100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll, 000010 srl}.
- BREAK: opcode == 0 and funct == 001101.
- Anything else is illegal.
- Handshake:
  - A transfer occurs when valid && ready.
  - In RUN, in_ready = !out_valid || out_ready (single-entry pipeline with pass-through on drain).
- Latency: a legal word accepted in cycle N gives out_valid = 1 with its fields in cycle N+1.
- Output hold: fields are held stable while out_valid && !out_ready.
- out_valid clears on an output transfer unless a new legal word is accepted in the same cycle, in which case the register reloads.
- Illegal word: consumed without being issued.
  - illegal pulses in cycle N+1 and illegal_count increments.
  - The output register is unaffected, so a held instruction stays held.
- issued_count increments on each out_valid && out_ready. Both counters stick at all-ones.
- All-zero word (sll r0,r0,0) is legal and is issued.
- State machine:
  - RUN: normal operation. A consumed BREAK is not issued and moves the state to DRAIN.
  - DRAIN: in_ready = 0. Move to HALTED once out_valid == 0, which can be the same cycle the last output transfers.
  - HALTED: in_ready = 0, halted = 1. resume moves the state to RUN next cycle. resume in RUN or DRAIN is ignored.
- Reset mid-operation: asynchronous clear. Any pending output is discarded, and counters, state and pulses all return to their reset values immediately.

Optional Feature:
- Macro SHAMT_CHECK_EN.
- Defined: add, sub, and and or with shamt != 0 are illegal, and sll/srl with rs != 0 are illegal.
- Undefined: shamt and rs are passed through unchecked for all functs.

Test Plan:
- Send 0x00011020 (add rd=2 rs=0 rt=1) with out_ready=1 -> next cycle out_valid=1, rs=0, rt=1, rd=2, shamt=0, funct=100000; issued_count=1.
- Back-to-back words 0x00011082 (srl rd=2 rt=1 shamt=2) and 0x00220022 (sub rd=0 rs=1 rt=2) with out_ready low for 3 cycles -> in_ready=0 while full; srl fields held unchanged; after out_ready rises, srl then sub issue in consecutive cycles; issued_count=2.
- Send 0x8C010004 (lw) -> no out_valid; illegal pulses for 1 cycle; illegal_count=1.
- Send 255+ illegal words -> illegal_count stays at 0xFF.
- With an add pending and out_ready=0, send 0x0000000D (BREAK):
  - State enters DRAIN, in_ready=0.
  - Raise out_ready -> add issues, halted=1.
  - Pulse resume -> halted=0, in_ready=1 next cycle.
- Assert rst while out_valid=1 -> out_valid, counters and halted drop to 0 without a clock edge.
- With SHAMT_CHECK_EN defined, send 0x00011060 (add with shamt=1) -> illegal pulses.
- Without SHAMT_CHECK_EN, send 0x00011060 -> issued with shamt=1.
